// File: rtl/jtag_tap_controller.sv
// jtag_tap_controller
//   IEEE 1149.1 TAP controller for the SiP test port. It runs the 16-state TAP
//   FSM from TMS and owns the instruction register and the BYPASS and IDCODE
//   data registers. It publishes tap_state and IR so the external data
//   registers can follow along, and it selects which serial output drives TDO.
//
// Ports
//   TCK        in   test clock; all state updates on the rising edge
//   TRST       in   synchronous active-high reset
//   TMS        in   test mode select
//   TDI        in   serial data in
//   config_tdo in   serial output of the 3D configuration data register
//   tap_state  out  current FSM state (registered, fixed 4-bit encoding)
//   IR         out  active (updated) instruction (registered)
//   TDO        out  serial data out
//   tdo_en     out  high while in SHIFT_DR or SHIFT_IR
module jtag_tap_controller #(
    parameter int unsigned          IR_WIDTH        = 4,
    parameter logic [31:0]          IDCODE_VAL      = 32'h1000_0001,
    parameter logic [IR_WIDTH-1:0]  INSTR_IDCODE    = 4'h1,
    parameter logic [IR_WIDTH-1:0]  INSTR_CONFIG_3D = 4'h3,
    parameter logic [IR_WIDTH-1:0]  INSTR_BYPASS    = 4'hF
) (
    input  logic                TCK,
    input  logic                TRST,
    input  logic                TMS,
    input  logic                TDI,
    input  logic                config_tdo,
    output logic [3:0]          tap_state,
    output logic [IR_WIDTH-1:0] IR,
    output logic                TDO,
    output logic                tdo_en
);

    // Encoding is shared with every downstream data register; do not reorder.
    typedef enum logic [3:0] {
        StTestLogicReset = 4'd0,
        StRunTestIdle    = 4'd1,
        StSelectDr       = 4'd2,
        StCaptureDr      = 4'd3,
        StShiftDr        = 4'd4,
        StExit1Dr        = 4'd5,
        StPauseDr        = 4'd6,
        StExit2Dr        = 4'd7,
        StUpdateDr       = 4'd8,
        StSelectIr       = 4'd9,
        StCaptureIr      = 4'd10,
        StShiftIr        = 4'd11,
        StExit1Ir        = 4'd12,
        StPauseIr        = 4'd13,
        StExit2Ir        = 4'd14,
        StUpdateIr       = 4'd15
    } tap_state_e;

    // Fixed pattern captured into the IR shift register (LSBs 01 as required).
    localparam logic [IR_WIDTH-1:0] IrCapture = {{(IR_WIDTH-1){1'b0}}, 1'b1};

    tap_state_e          state_q, state_d;
    logic [IR_WIDTH-1:0] ir_q, ir_d;
    logic [IR_WIDTH-1:0] ir_sr_q, ir_sr_d;
    logic                bypass_q, bypass_d;
    logic [31:0]         idcode_sr_q, idcode_sr_d;

    logic idcode_sel;
    logic config_sel;
    logic bypass_sel;

    assign idcode_sel = (ir_q == INSTR_IDCODE);
    assign config_sel = (ir_q == INSTR_CONFIG_3D);
    // Undefined codes fall back to BYPASS so the chain length stays defined.
    assign bypass_sel = (ir_q == INSTR_BYPASS) || !(idcode_sel || config_sel);

    // Next-state transition function.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StTestLogicReset: state_d = TMS ? StTestLogicReset : StRunTestIdle;
            StRunTestIdle:    state_d = TMS ? StSelectDr       : StRunTestIdle;
            StSelectDr:       state_d = TMS ? StSelectIr       : StCaptureDr;
            StCaptureDr:      state_d = TMS ? StExit1Dr        : StShiftDr;
            StShiftDr:        state_d = TMS ? StExit1Dr        : StShiftDr;
            StExit1Dr:        state_d = TMS ? StUpdateDr       : StPauseDr;
            StPauseDr:        state_d = TMS ? StExit2Dr        : StPauseDr;
            StExit2Dr:        state_d = TMS ? StUpdateDr       : StShiftDr;
            StUpdateDr:       state_d = TMS ? StSelectDr       : StRunTestIdle;
            StSelectIr:       state_d = TMS ? StTestLogicReset : StCaptureIr;
            StCaptureIr:      state_d = TMS ? StExit1Ir        : StShiftIr;
            StShiftIr:        state_d = TMS ? StExit1Ir        : StShiftIr;
            StExit1Ir:        state_d = TMS ? StUpdateIr       : StPauseIr;
            StPauseIr:        state_d = TMS ? StExit2Ir        : StPauseIr;
            StExit2Ir:        state_d = TMS ? StUpdateIr       : StShiftIr;
            StUpdateIr:       state_d = TMS ? StSelectDr       : StRunTestIdle;
            default:          state_d = StTestLogicReset;
        endcase
    end

    // Register actions keyed on the state held during the edge.
    always_comb begin
        ir_d        = ir_q;
        ir_sr_d     = ir_sr_q;
        bypass_d    = bypass_q;
        idcode_sr_d = idcode_sr_q;
        case (state_q)
            StTestLogicReset: ir_d    = INSTR_IDCODE;
            StCaptureIr:      ir_sr_d = IrCapture;
            StShiftIr:        ir_sr_d = {TDI, ir_sr_q[IR_WIDTH-1:1]};
            StUpdateIr:       ir_d    = ir_sr_q;
            StCaptureDr: begin
                if (bypass_sel) bypass_d    = 1'b0;
                if (idcode_sel) idcode_sr_d = IDCODE_VAL;
            end
            StShiftDr: begin
                if (bypass_sel) bypass_d    = TDI;
                if (idcode_sel) idcode_sr_d = {TDI, idcode_sr_q[31:1]};
            end
            default: ;
        endcase
    end

    // TRST wins over TMS; a mid-scan reset never reaches an UPDATE state.
    always_ff @(posedge TCK) begin
        if (TRST) begin
            state_q     <= StTestLogicReset;
            ir_q        <= INSTR_IDCODE;
            ir_sr_q     <= IrCapture;
            bypass_q    <= 1'b0;
            idcode_sr_q <= IDCODE_VAL;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            ir_sr_q     <= ir_sr_d;
            bypass_q    <= bypass_d;
            idcode_sr_q <= idcode_sr_d;
        end
    end

    assign tap_state = state_q;
    assign IR        = ir_q;
    assign tdo_en    = (state_q == StShiftDr) || (state_q == StShiftIr);

    // Serial output mux; all sources are registered except config_tdo, which
    // is itself a register output of the downstream config chain.
    always_comb begin
        TDO = 1'b0;
        if (state_q == StShiftIr) begin
            TDO = ir_sr_q[0];
        end else if (state_q == StShiftDr) begin
            if (idcode_sel)      TDO = idcode_sr_q[0];
            else if (config_sel) TDO = config_tdo;
            else                 TDO = bypass_q;
        end
    end

endmodule
